// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed program image, one byte at a time,
// into instruction memory as little-endian 32-bit words.
//
// Load format: 4-byte little-endian word count N, then N words of 4 bytes each
// (least significant byte first). When IMEM_LOADER_CKSUM_EN is defined, one
// trailing byte follows the data. It must equal the XOR of all data bytes.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   start      - one-cycle request to begin a load (honoured only when idle)
//   in_data    - incoming byte
//   in_valid   - in_data valid; a byte moves when in_valid && in_ready
//   in_ready   - loader accepts a byte this cycle (LEN/DATA/CKSUM only)
//   imem_we    - one-cycle write strobe per assembled word
//   imem_addr  - byte address of the write (BASE_ADDR + 4*k); held between writes
//   imem_wdata - assembled word; held between writes
//   busy       - high whenever the loader is not idle
//   done       - one-cycle pulse at the end of every load
//   err        - sticky error (length too large, or checksum mismatch);
//                cleared by the next accepted start
//
// Parameters:
//   MAX_WORDS  - largest word count accepted per load
//   BASE_ADDR  - byte address of the first written word (word-aligned)
//
// Macro IMEM_LOADER_CKSUM_EN: enables the trailing checksum byte and its check.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 32768,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
`ifdef IMEM_LOADER_CKSUM_EN
    CKSUM,
`endif
    DONE
  } state_t;

  state_t      state;
  logic [1:0]  byte_cnt;   // byte position within the current 4-byte group
  logic [23:0] len_sr;     // first three length bytes, newest at the top
  logic [23:0] word_sr;    // first three data bytes of the current word
  logic [31:0] word_cnt;   // index of the word being assembled
  logic [31:0] n_words;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]  cksum;
`endif

  logic        accept;
  logic [31:0] len_word;
  logic        last_word;

  assign accept    = in_valid && in_ready;
  // The fourth byte completes the value in the same cycle it is accepted.
  assign len_word  = {in_data, len_sr};
  assign last_word = (word_cnt == n_words - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      byte_cnt   <= '0;
      len_sr     <= '0;
      word_sr    <= '0;
      word_cnt   <= '0;
      n_words    <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum      <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= LEN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            err      <= 1'b0;
            byte_cnt <= '0;
            len_sr   <= '0;
            word_sr  <= '0;
            word_cnt <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum    <= '0;
`endif
          end
        end

        LEN: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            len_sr   <= {in_data, len_sr[23:8]};
            if (byte_cnt == 2'd3) begin
              n_words <= len_word;
              if (len_word == '0) begin
                state    <= DONE;
                in_ready <= 1'b0;
              end else if (len_word > MAX_WORDS_W) begin
                err      <= 1'b1;
                state    <= DONE;
                in_ready <= 1'b0;
              end else begin
                state <= DATA;
              end
            end
          end
        end

        DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_sr  <= {in_data, word_sr[23:8]};
`ifdef IMEM_LOADER_CKSUM_EN
            cksum    <= cksum ^ in_data;
`endif
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= BASE_ADDR + (word_cnt << 2);
              imem_wdata <= {in_data, word_sr};
              word_cnt   <= word_cnt + 32'd1;
              if (last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
                state    <= CKSUM;
`else
                state    <= DONE;
                in_ready <= 1'b0;
`endif
              end
            end
          end
        end

`ifdef IMEM_LOADER_CKSUM_EN
        CKSUM: begin
          if (accept) begin
            err      <= (in_data != cksum);
            state    <= DONE;
            in_ready <= 1'b0;
          end
        end
`endif

        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL provide parameter MAX_WORDS, default 32768, meaning max words accepted per load.
REQ-002 SHALL provide parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of first written word (word-aligned).
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port in_data  input  8  incoming byte (e.g. from UART receiver).
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts byte this cycle.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port imem_addr  output  32  byte address of write, bits [1:0] always 0.
REQ-011 SHALL have port imem_wdata  output  32  word to write.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at load end.
REQ-014 SHALL have port err  output  1  sticky error flag.

Function
REQ-015 SHALL implement states IDLE, LEN, DATA, CKSUM, DONE.
REQ-016 Byte transfer SHALL occur only in a cycle with in_valid=1 and in_ready=1; in_ready=1 exactly in LEN, DATA, CKSUM.
REQ-017 IDLE: start=1 -> LEN, clear err, byte/word counters, checksum; start ignored in all other states.
REQ-018 LEN: accept 4 bytes, little-endian (first byte = bits [7:0]), forming word count N.
REQ-019 After 4th LEN byte: N=0 -> DONE; N>MAX_WORDS -> err=1, DONE; otherwise -> DATA.
REQ-020 DATA: accept bytes little-endian; 4th byte of word k accepted in cycle t -> cycle t+1 imem_we=1, imem_addr=BASE_ADDR+4*k, imem_wdata=assembled word.
REQ-021 imem_we SHALL be high exactly one cycle per word; no back-pressure from memory (single-cycle write).
REQ-022 in_ready SHALL stay high during DATA including the imem_we cycle; a byte accepted in that cycle starts word k+1.
REQ-023 After word N-1's 4th byte: -> CKSUM if feature enabled, else -> DONE.
REQ-024 DONE: done=1 for one cycle, then IDLE; err held until next accepted start.
REQ-025 Without errors, last data byte at t -> imem_we at t+1 -> done at t+2 (no checksum).
REQ-026 imem_addr/imem_wdata SHALL hold last written values when imem_we=0.
REQ-027 Counters 32-bit; word index never exceeds MAX_WORDS-1, so imem_addr never wraps.

Reset
REQ-028 rst=1 SHALL, at next clk edge, force IDLE and in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, err=0.
REQ-029 rst mid-load SHALL abandon the load with no further imem_we; partial word discarded.
REQ-030 rst SHALL take priority over start in the same cycle.

Configuration
REQ-031 Macro IMEM_LOADER_CKSUM_EN defined: running XOR of all DATA bytes; one CKSUM byte accepted after data; mismatch -> err=1; then DONE.
REQ-032 Macro undefined: no CKSUM state or checksum logic; err set only by length error; DATA goes directly to DONE.

Verification
REQ-033 start, bytes 02 00 00 00, 13 00 00 00, 6F 00 00 00 -> imem_we at addr 0x0 data 0x00000013, addr 0x4 data 0x0000006F, done two cycles after last byte, err=0.
REQ-034 start, length 00 00 00 00 -> no imem_we, done pulse, err=0, in_ready=0 afterward.
REQ-035 start, length 01 80 00 00 (32769) with MAX_WORDS=32768 -> err=1, done pulse, no imem_we.
REQ-036 Length 1, data bytes with in_valid gaps of 0-3 cycles -> single imem_we with 0x44332211 for bytes 11 22 33 44; in_valid during IDLE ignored.
REQ-037 rst asserted after 2 of 4 data bytes of word 1 -> IDLE next cycle, no further imem_we; new start reloads from BASE_ADDR.
REQ-038 With IMEM_LOADER_CKSUM_EN, length 1, data 11 22 33 44, cksum 44 -> err=0; cksum 00 -> err=1, done pulse.
